led_frame_ctrl: RTL and testbench

- Double-buffered frame store and update sequencer for the row-multiplexed LED matrix driver.
- A host writes rows into a back buffer through a valid/ready port. The front buffer drives the driver's per-row column inputs.
- Swaps happen only at a frame boundary, so there is no tearing. After each swap the new front is copied into the back, so the host can make incremental edits.

---
 rtl/led_frame_ctrl_pkg.sv | 16 +
 rtl/led_frame_buf.sv | 42 ++++
 rtl/led_frame_ctrl.sv | 95 +++++++++
 tb/tb_led_frame_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_ctrl_pkg.sv
// Shared definitions for the LED frame store: sequencer state encoding and
// the elaboration-time row-index width check.
package led_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } state_t;

    // The row index must be able to address every physical row.
    function automatic bit row_width_ok(int unsigned w, int unsigned n);
        return (64'd1 << w) >= 64'(n);
    endfunction

endpackage

// File: rtl/led_frame_buf.sv
// Two-bank row store: one write port (bank/row/data/enable), one row read
// port from the front bank, and the full front bank as a combinational mux.
module led_frame_buf #(
    parameter int NUM_ROWS = 4,
    parameter int ROW_W    = 2,
    parameter int NUM_COLS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic                we_bank,
    input  logic [ROW_W-1:0]    we_row,
    input  logic [NUM_COLS-1:0] we_data,
    input  logic                front_sel,
    input  logic [ROW_W-1:0]    rd_row,
    output logic [NUM_COLS-1:0] rd_data,
    output logic [NUM_COLS-1:0] rows [0:NUM_ROWS-1]
);

    // Sized to the full index range so any row value indexes legally;
    // entries at or above NUM_ROWS are never written.
    localparam int DEPTH = 1 << ROW_W;

    logic [NUM_COLS-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < DEPTH; r++)
                    mem[b][r] <= '0;
        end else if (we && (int'(we_row) < NUM_ROWS)) begin
            mem[we_bank][we_row] <= we_data;
        end
    end

    assign rd_data = mem[front_sel][rd_row];

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_rows
        assign rows[r] = mem[front_sel][r];
    end

endmodule

// File: rtl/led_frame_ctrl.sv
// Double-buffered LED frame store: host writes go to the back bank, swaps
// land on a frame tick, then the new front is copied back row by row.
module led_frame_ctrl
    import led_frame_ctrl_pkg::*;
#(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_ROWS_WIDTH = 2,
    parameter int NUM_COLS       = 8
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic [NUM_ROWS_WIDTH-1:0] i_wr_row,
    input  logic [NUM_COLS-1:0]       i_wr_data,
    input  logic                      i_swap_req,
    output logic                      o_swap_ack,
    input  logic                      i_frame_tick,
    output logic [NUM_COLS-1:0]       o_rows [0:NUM_ROWS-1],
    output logic                      o_wr_err,
    output logic                      o_busy
);

    if (!row_width_ok(NUM_ROWS_WIDTH, NUM_ROWS)) begin : g_bad_width
        $error("NUM_ROWS_WIDTH too narrow for NUM_ROWS");
    end

    localparam logic [NUM_ROWS_WIDTH-1:0] LAST_ROW = NUM_ROWS_WIDTH'(NUM_ROWS - 1);

    state_t                    state_q, state_d;
    logic                      front_sel_q;
    logic [NUM_ROWS_WIDTH-1:0] cnt_q;
    logic                      swap_ack_q, wr_err_q;
    logic                      wr_fire, wr_oob, tick_hit, copying;
    logic [NUM_COLS-1:0]       rd_data;

    assign o_wr_ready = (state_q == IDLE) & i_rst_n;
    assign o_busy     = (state_q != IDLE);
    assign o_swap_ack = swap_ack_q;
    assign o_wr_err   = wr_err_q;
    assign wr_fire    = i_wr_valid & o_wr_ready;
    assign wr_oob     = int'(i_wr_row) >= NUM_ROWS;
    assign tick_hit   = (state_q == PENDING) & i_frame_tick;
    assign copying    = (state_q == COPY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_swap_req)          state_d = PENDING;
            PENDING: if (i_frame_tick)        state_d = COPY;
            COPY:    if (cnt_q == LAST_ROW)   state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            cnt_q       <= '0;
            swap_ack_q  <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            swap_ack_q <= tick_hit;
            wr_err_q   <= wr_fire & wr_oob;
            if (tick_hit) begin
                front_sel_q <= ~front_sel_q;
                cnt_q       <= '0;
            end else if (copying) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // The back bank is always ~front_sel; during COPY it is refilled from
    // the freshly swapped-in front so the host can edit incrementally.
    led_frame_buf #(
        .NUM_ROWS (NUM_ROWS),
        .ROW_W    (NUM_ROWS_WIDTH),
        .NUM_COLS (NUM_COLS)
    ) u_buf (
        .clk       (clk),
        .rst_n     (i_rst_n),
        .we        (copying | (wr_fire & ~wr_oob)),
        .we_bank   (~front_sel_q),
        .we_row    (copying ? cnt_q : i_wr_row),
        .we_data   (copying ? rd_data : i_wr_data),
        .front_sel (front_sel_q),
        .rd_row    (cnt_q),
        .rd_data   (rd_data),
        .rows      (o_rows)
    );

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Bench for led_frame_ctrl: directed stimulus pushes expected frames into a
// scoreboard that a negedge monitor drains on every swap ack / write error.
module tb_led_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       rst_a, wv_a, swap_a, tick_a;
    logic [1:0] row_a;
    logic [7:0] data_a;
    logic       ready_a, ack_a, err_a, busy_a;
    logic [7:0] rows_a [0:3];
    logic [31:0] pack_a;

    // Instance B: 3-bit row index over 4 rows
    logic       rst_b, wv_b, swap_b, tick_b;
    logic [2:0] row_b;
    logic [7:0] data_b;
    logic       ready_b, ack_b, err_b, busy_b;
    logic [7:0] rows_b [0:3];
    logic [31:0] pack_b;

    assign pack_a = {rows_a[3], rows_a[2], rows_a[1], rows_a[0]};
    assign pack_b = {rows_b[3], rows_b[2], rows_b[1], rows_b[0]};

    led_frame_ctrl dut_a (
        .clk(clk), .i_rst_n(rst_a), .i_wr_valid(wv_a), .o_wr_ready(ready_a),
        .i_wr_row(row_a), .i_wr_data(data_a), .i_swap_req(swap_a),
        .o_swap_ack(ack_a), .i_frame_tick(tick_a), .o_rows(rows_a),
        .o_wr_err(err_a), .o_busy(busy_a)
    );

    led_frame_ctrl #(.NUM_ROWS(4), .NUM_ROWS_WIDTH(3), .NUM_COLS(8)) dut_b (
        .clk(clk), .i_rst_n(rst_b), .i_wr_valid(wv_b), .o_wr_ready(ready_b),
        .i_wr_row(row_b), .i_wr_data(data_b), .i_swap_req(swap_b),
        .o_swap_ack(ack_b), .i_frame_tick(tick_b), .o_rows(rows_b),
        .o_wr_err(err_b), .o_busy(busy_b)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int err_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [1:0] r, input logic [7:0] d);
        wv_a = 1'b1; row_a = r; data_a = d;
        cyc();
        wv_a = 1'b0;
    endtask

    task automatic wr_b(input logic [2:0] r, input logic [7:0] d);
        wv_b = 1'b1; row_b = r; data_b = d;
        cyc();
        wv_b = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (ack_a === 1'b1) begin
            if (q_a.size() == 0) chk("unexpected_ack_a", 32'(ack_a), 32'd0);
            else chk("frame_a", pack_a, q_a.pop_front());
        end
        if (ack_b === 1'b1) begin
            if (q_b.size() == 0) chk("unexpected_ack_b", 32'(ack_b), 32'd0);
            else chk("frame_b", pack_b, q_b.pop_front());
        end
        if (err_a === 1'b1) chk("unexpected_err_a", 32'(err_a), 32'd0);
        if (err_b === 1'b1) begin
            if (err_exp == 0) chk("unexpected_err_b", 32'(err_b), 32'd0);
            else begin
                err_exp--;
                chk("err_b_pulse", 32'(err_b), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_a = 0; wv_a = 0; swap_a = 0; tick_a = 0; row_a = '0; data_a = '0;
        rst_b = 0; wv_b = 0; swap_b = 0; tick_b = 0; row_b = '0; data_b = '0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_ready_low", 32'(ready_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        cyc();
        rst_a = 1; rst_b = 1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready_a), 32'd1);
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        chk("post_rst_rows", pack_a, 32'h0);
        cyc();

        // Full frame, swap, tick five cycles later
        wr_a(2'd0, 8'hA5); wr_a(2'd1, 8'h3C); wr_a(2'd2, 8'hFF); wr_a(2'd3, 8'h01);
        @(negedge clk);
        chk("rows_hidden_writes", pack_a, 32'h0);
        cyc();
        swap_a = 1; q_a.push_back(32'h01FF3CA5);
        cyc();
        swap_a = 0;
        repeat (4) cyc();
        tick_a = 1;
        @(negedge clk);
        chk("rows_hold_pending", pack_a, 32'h0);
        chk("busy_pending", 32'(busy_a), 32'd1);
        chk("ready_pending", 32'(ready_a), 32'd0);
        cyc();
        tick_a = 0;
        @(negedge clk);
        chk("ack_cycle", 32'(ack_a), 32'd1);
        chk("ready_copy_0", 32'(ready_a), 32'd0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            @(negedge clk);
            chk("ready_copy", 32'(ready_a), 32'd0);
            chk("ack_one_cycle", 32'(ack_a), 32'd0);
        end
        cyc();
        @(negedge clk);
        chk("ready_after_copy", 32'(ready_a), 32'd1);
        chk("idle_after_copy", 32'(busy_a), 32'd0);
        cyc();

        // Incremental edit relies on the copied-back frame
        wr_a(2'd2, 8'h0F);
        swap_a = 1; q_a.push_back(32'h010F3CA5);
        cyc();
        swap_a = 0;
        cyc();
        tick_a = 1;
        cyc();
        tick_a = 0;
        repeat (6) cyc();
        @(negedge clk);
        chk("idle_after_swap2", 32'(busy_a), 32'd0);
        cyc();

        // Write + swap + tick together: tick ignored, write kept
        wv_a = 1; row_a = 2'd1; data_a = 8'h77; swap_a = 1; tick_a = 1;
        q_a.push_back(32'h010F77A5);
        cyc();
        wv_a = 0; swap_a = 0; tick_a = 0;
        @(negedge clk);
        chk("same_cycle_tick_no_ack", 32'(ack_a), 32'd0);
        chk("same_cycle_tick_pending", 32'(busy_a), 32'd1);
        chk("same_cycle_rows_old", pack_a, 32'h010F3CA5);
        cyc();
        swap_a = 1;
        cyc();
        swap_a = 0;
        cyc();
        tick_a = 1;
        cyc();
        tick_a = 0; swap_a = 1;
        cyc();
        swap_a = 0; tick_a = 1;
        cyc();
        tick_a = 0;
        repeat (5) cyc();
        @(negedge clk);
        chk("no_requeued_swap", 32'(busy_a), 32'd0);
        chk("ready_after_swap3", 32'(ready_a), 32'd1);
        cyc();

        // Reset in the middle of COPY
        wr_a(2'd0, 8'h11);
        swap_a = 1; q_a.push_back(32'h010F7711);
        cyc();
        swap_a = 0; tick_a = 1;
        cyc();
        tick_a = 0;
        cyc();
        rst_a = 0;
        cyc();
        rst_a = 1;
        @(negedge clk);
        chk("abort_rows_clear", pack_a, 32'h0);
        chk("abort_idle", 32'(busy_a), 32'd0);
        chk("abort_ready", 32'(ready_a), 32'd1);
        chk("abort_no_ack", 32'(ack_a), 32'd0);
        repeat (3) cyc();

        // Out-of-range row on the wider-index instance
        wr_b(3'd1, 8'h55);
        err_exp++;
        wr_b(3'd4, 8'hEE);
        @(negedge clk);
        chk("oob_err_pulse", 32'(err_b), 32'd1);
        chk("oob_front_unchanged", pack_b, 32'h0);
        cyc();
        @(negedge clk);
        chk("oob_err_single", 32'(err_b), 32'd0);
        cyc();
        swap_b = 1; q_b.push_back(32'h00005500);
        cyc();
        swap_b = 0; tick_b = 1;
        cyc();
        tick_b = 0;
        repeat (6) cyc();

        @(negedge clk);
        chk("ack_a_all_seen", 32'(q_a.size()), 32'd0);
        chk("ack_b_all_seen", 32'(q_b.size()), 32'd0);
        chk("err_b_all_seen", 32'(err_exp), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
